// File: rtl/lc3b_alu_arbiter_if.sv
// Request/response channel between one ALU requester and the arbiter.
// The master is the requester; the slave is the arbiter.
interface lc3b_alu_arbiter_if #(
   parameter int W    = 16,
   parameter int CTLW = 3
);
   logic            req_valid;
   logic            req_ready;
   logic [CTLW-1:0] req_op;
   logic [W-1:0]    req_a;
   logic [W-1:0]    req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [W-1:0]    rsp_data;
   logic [2:0]      rsp_nzp;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_nzp
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_nzp
   );
endinterface

// File: rtl/lc3b_alu_arbiter.sv
// Round-robin sharing of one combinational LC-3b ALU between two requesters.
// Each requester owns a one-entry result slot carrying the data and its N/Z/P code.
module lc3b_alu_arbiter #(
   parameter int W    = 16,
   parameter int CTLW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   lc3b_alu_arbiter_if.slave ch0,
   lc3b_alu_arbiter_if.slave ch1,
   output logic [W-1:0]      alu_a_o,
   output logic [W-1:0]      alu_b_o,
   output logic [CTLW-1:0]   alu_ctl_o,
   input  logic [W-1:0]      alu_out_i
);
   localparam int NUM_REQ = 2;

   logic [NUM_REQ-1:0]                 req_vld;
   logic [NUM_REQ-1:0]                 rsp_rdy;
   logic [NUM_REQ-1:0][CTLW-1:0]       req_op;
   logic [NUM_REQ-1:0][W-1:0]          req_a;
   logic [NUM_REQ-1:0][W-1:0]          req_b;
   logic [NUM_REQ-1:0]                 elig;
   logic [NUM_REQ-1:0]                 grant;
   logic [2:0]                         alu_nzp;

   logic [NUM_REQ-1:0]                 rsp_vld_q, rsp_vld_d;
   logic [NUM_REQ-1:0][W-1:0]          rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0][2:0]            rsp_nzp_q, rsp_nzp_d;
   logic                               rr_ptr_q, rr_ptr_d;

   assign req_vld = {ch1.req_valid, ch0.req_valid};
   assign rsp_rdy = {ch1.rsp_ready, ch0.rsp_ready};
   assign req_op  = {ch1.req_op, ch0.req_op};
   assign req_a   = {ch1.req_a, ch0.req_a};
   assign req_b   = {ch1.req_b, ch0.req_b};

   // A requester may be granted only if its slot is empty or drains this cycle;
   // nothing is granted while reset is held so the ALU pins stay quiet.
   assign elig = {NUM_REQ{rst_n}} & req_vld & (~rsp_vld_q | rsp_rdy);

   // Round-robin pick: pointer decides only when both contend.
   always_comb begin
      grant = '0;
      if (&elig) grant[rr_ptr_q] = 1'b1;
      else       grant = elig;
   end

   // Steer the granted requester onto the ALU pins; idle pins are zero.
   always_comb begin
      alu_a_o   = '0;
      alu_b_o   = '0;
      alu_ctl_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            alu_a_o   = req_a[i];
            alu_b_o   = req_b[i];
            alu_ctl_o = req_op[i];
         end
      end
   end

   assign alu_nzp = alu_out_i[W-1]      ? 3'b100 :
                    (alu_out_i == '0)   ? 3'b010 : 3'b001;

   // Slot next state: a grant reloads (even if draining), otherwise a drain empties.
   always_comb begin
      rsp_vld_d  = rsp_vld_q;
      rsp_data_d = rsp_data_q;
      rsp_nzp_d  = rsp_nzp_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            rsp_vld_d[i]  = 1'b1;
            rsp_data_d[i] = alu_out_i;
            rsp_nzp_d[i]  = alu_nzp;
         end else if (rsp_rdy[i] && rsp_vld_q[i]) begin
            rsp_vld_d[i]  = 1'b0;
         end
      end
   end

   // The pointer only moves on contention; the winner yields to the other side.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (&elig) rr_ptr_d = ~rr_ptr_q;
   end

   // Result slots and arbitration pointer; reset drops any in-flight capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
         rsp_nzp_q  <= '0;
         rr_ptr_q   <= 1'b0;
      end else begin
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
         rsp_nzp_q  <= rsp_nzp_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign ch0.req_ready = grant[0];
   assign ch1.req_ready = grant[1];
   assign ch0.rsp_valid = rsp_vld_q[0];
   assign ch1.rsp_valid = rsp_vld_q[1];
   assign ch0.rsp_data  = rsp_data_q[0];
   assign ch1.rsp_data  = rsp_data_q[1];
   assign ch0.rsp_nzp   = rsp_nzp_q[0];
   assign ch1.rsp_nzp   = rsp_nzp_q[1];
endmodule

// File: tb/tb_lc3b_alu_arbiter.sv
// Directed bench for lc3b_alu_arbiter with a behavioural LC-3b ALU attached.
module tb_lc3b_alu_arbiter;
   localparam int W    = 16;
   localparam int CTLW = 3;
   localparam int NV   = 15;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [W-1:0]    alu_a, alu_b, alu_out;
   logic [CTLW-1:0] alu_ctl;
   int              n_chk = 0;
   int              n_fail = 0;

   lc3b_alu_arbiter_if #(.W(W), .CTLW(CTLW)) ch0 ();
   lc3b_alu_arbiter_if #(.W(W), .CTLW(CTLW)) ch1 ();

   lc3b_alu_arbiter #(.W(W), .CTLW(CTLW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch0       (ch0),
      .ch1       (ch1),
      .alu_a_o   (alu_a),
      .alu_b_o   (alu_b),
      .alu_ctl_o (alu_ctl),
      .alu_out_i (alu_out)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: shifts take the full 16-bit B as the count.
   always_comb begin
      alu_out = alu_a;
      case (alu_ctl)
         3'd0:    alu_out = alu_a + alu_b;
         3'd1:    alu_out = alu_a & alu_b;
         3'd2:    alu_out = alu_a ^ alu_b;
         3'd3:    alu_out = alu_a << alu_b;
         3'd4:    alu_out = alu_a >> alu_b;
         3'd5:    alu_out = $unsigned($signed(alu_a) >>> alu_b);
         default: alu_out = alu_a;
      endcase
   end

   typedef struct {
      logic        v0;  logic [2:0] op0; logic [15:0] a0; logic [15:0] b0;
      logic        v1;  logic [2:0] op1; logic [15:0] a1; logic [15:0] b1;
      logic [1:0]  rdy; logic [1:0] rv;
      logic [15:0] d0;  logic [2:0] n0;  logic [15:0] d1; logic [2:0] n1;
   } vec_t;

   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [2:0] op0, input logic [15:0] a0,
                        input logic [15:0] b0, input logic v1, input logic [2:0] op1,
                        input logic [15:0] a1, input logic [15:0] b1);
      ch0.req_valid = v0; ch0.req_op = op0; ch0.req_a = a0; ch0.req_b = b0;
      ch1.req_valid = v1; ch1.req_op = op1; ch1.req_a = a1; ch1.req_b = b1;
   endtask

   initial begin
      logic [15:0] ea, eb;
      logic [2:0]  ec;

      // rsp ready held high throughout the table, so slots reload or drain every cycle
      tbl[0]  = '{1'b1,3'd0,16'h7FFF,16'h0001, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'h8000,3'b100,16'h0000,3'b000};
      tbl[1]  = '{1'b1,3'd0,16'h0001,16'h0002, 1'b1,3'd1,16'h00F0,16'h0F00, 2'b01,2'b01,16'h0003,3'b001,16'h0000,3'b000};
      tbl[2]  = '{1'b1,3'd0,16'h0001,16'h0002, 1'b1,3'd1,16'h00F0,16'h0F00, 2'b10,2'b10,16'h0000,3'b000,16'h0000,3'b010};
      tbl[3]  = '{1'b1,3'd0,16'h0001,16'h0002, 1'b1,3'd1,16'h00F0,16'h0F00, 2'b01,2'b01,16'h0003,3'b001,16'h0000,3'b000};
      tbl[4]  = '{1'b1,3'd0,16'h0001,16'h0002, 1'b1,3'd1,16'h00F0,16'h0F00, 2'b10,2'b10,16'h0000,3'b000,16'h0000,3'b010};
      tbl[5]  = '{1'b1,3'd4,16'h8000,16'h0004, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'h0800,3'b001,16'h0000,3'b000};
      tbl[6]  = '{1'b1,3'd5,16'h8000,16'h0004, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'hF800,3'b100,16'h0000,3'b000};
      tbl[7]  = '{1'b0,3'd0,16'h0000,16'h0000, 1'b1,3'd2,16'h1234,16'h00FF, 2'b10,2'b10,16'h0000,3'b000,16'h12CB,3'b001};
      tbl[8]  = '{1'b0,3'd0,16'h0000,16'h0000, 1'b1,3'd3,16'h0001,16'h000F, 2'b10,2'b10,16'h0000,3'b000,16'h8000,3'b100};
      tbl[9]  = '{1'b1,3'd6,16'h0000,16'h1234, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'h0000,3'b010,16'h0000,3'b000};
      tbl[10] = '{1'b1,3'd7,16'h0005,16'hFFFF, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'h0005,3'b001,16'h0000,3'b000};
      tbl[11] = '{1'b1,3'd3,16'hFFFF,16'h0010, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'h0000,3'b010,16'h0000,3'b000};
      tbl[12] = '{1'b0,3'd0,16'h0000,16'h0000, 1'b0,3'd0,16'h0000,16'h0000, 2'b00,2'b00,16'h0000,3'b000,16'h0000,3'b000};
      tbl[13] = '{1'b1,3'd0,16'hFFFF,16'h0001, 1'b1,3'd1,16'hFFFF,16'hFFFF, 2'b01,2'b01,16'h0000,3'b010,16'h0000,3'b000};
      tbl[14] = '{1'b1,3'd5,16'h8000,16'h0010, 1'b0,3'd0,16'h0000,16'h0000, 2'b01,2'b01,16'hFFFF,3'b100,16'h0000,3'b000};

      // Reset held two cycles with both requesters pushing
      rst_n = 1'b0;
      ch0.rsp_ready = 1'b1; ch1.rsp_ready = 1'b1;
      drive(1'b1, 3'd0, 16'h1111, 16'h2222, 1'b1, 3'd1, 16'h3333, 16'h4444);
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready0", 32'(ch0.req_ready), 32'd0);
      chk("rst ready1", 32'(ch1.req_ready), 32'd0);
      chk("rst rsp0_valid", 32'(ch0.rsp_valid), 32'd0);
      chk("rst rsp1_valid", 32'(ch1.rsp_valid), 32'd0);
      chk("rst rsp0_nzp", 32'(ch0.rsp_nzp), 32'd0);
      chk("rst rsp1_nzp", 32'(ch1.rsp_nzp), 32'd0);
      chk("rst rsp0_data", 32'(ch0.rsp_data), 32'd0);
      chk("rst alu_a", 32'(alu_a), 32'd0);
      chk("rst alu_b", 32'(alu_b), 32'd0);
      chk("rst alu_ctl", 32'(alu_ctl), 32'd0);
      rst_n = 1'b1;

      // Table: one vector per cycle, combinational checks then registered checks
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
               tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1);
         #1;
         chk($sformatf("v%0d ready0", i), 32'(ch0.req_ready), 32'(tbl[i].rdy[0]));
         chk($sformatf("v%0d ready1", i), 32'(ch1.req_ready), 32'(tbl[i].rdy[1]));
         ea = 16'h0; eb = 16'h0; ec = 3'd0;
         if (tbl[i].rdy[0]) begin ea = tbl[i].a0; eb = tbl[i].b0; ec = tbl[i].op0; end
         else if (tbl[i].rdy[1]) begin ea = tbl[i].a1; eb = tbl[i].b1; ec = tbl[i].op1; end
         chk($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(ea));
         chk($sformatf("v%0d alu_b", i), 32'(alu_b), 32'(eb));
         chk($sformatf("v%0d alu_ctl", i), 32'(alu_ctl), 32'(ec));
         @(posedge clk); #1;
         chk($sformatf("v%0d rsp0_valid", i), 32'(ch0.rsp_valid), 32'(tbl[i].rv[0]));
         chk($sformatf("v%0d rsp1_valid", i), 32'(ch1.rsp_valid), 32'(tbl[i].rv[1]));
         if (tbl[i].rv[0]) begin
            chk($sformatf("v%0d rsp0_data", i), 32'(ch0.rsp_data), 32'(tbl[i].d0));
            chk($sformatf("v%0d rsp0_nzp", i), 32'(ch0.rsp_nzp), 32'(tbl[i].n0));
         end
         if (tbl[i].rv[1]) begin
            chk($sformatf("v%0d rsp1_data", i), 32'(ch1.rsp_data), 32'(tbl[i].d1));
            chk($sformatf("v%0d rsp1_nzp", i), 32'(ch1.rsp_nzp), 32'(tbl[i].n1));
         end
      end

      // Backpressure: slot 0 not drained; pointer currently favours requester 1
      drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0);
      @(posedge clk); #1;
      chk("bp idle rsp0_valid", 32'(ch0.rsp_valid), 32'd0);
      ch0.rsp_ready = 1'b0;
      drive(1'b1, 3'd0, 16'h0010, 16'h0001, 1'b1, 3'd0, 16'h0001, 16'h0001);
      #1;
      chk("bp A ready0", 32'(ch0.req_ready), 32'd0);
      chk("bp A ready1", 32'(ch1.req_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp A rsp1_data", 32'(ch1.rsp_data), 32'h0002);
      chk("bp B ready0", 32'(ch0.req_ready), 32'd1);
      chk("bp B ready1", 32'(ch1.req_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp B rsp0_valid", 32'(ch0.rsp_valid), 32'd1);
      chk("bp B rsp0_data", 32'(ch0.rsp_data), 32'h0011);
      drive(1'b1, 3'd0, 16'h0020, 16'h0002, 1'b1, 3'd0, 16'h0003, 16'h0001);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("bp stall%0d ready0", c), 32'(ch0.req_ready), 32'd0);
         chk($sformatf("bp stall%0d ready1", c), 32'(ch1.req_ready), 32'd1);
         @(posedge clk); #1;
         chk($sformatf("bp stall%0d rsp0_data", c), 32'(ch0.rsp_data), 32'h0011);
         chk($sformatf("bp stall%0d rsp0_valid", c), 32'(ch0.rsp_valid), 32'd1);
         chk($sformatf("bp stall%0d rsp1_data", c), 32'(ch1.rsp_data), 32'h0004);
      end
      ch1.req_valid = 1'b0;
      ch0.rsp_ready = 1'b1;
      #1;
      chk("bp release ready0", 32'(ch0.req_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp release rsp0_valid", 32'(ch0.rsp_valid), 32'd1);
      chk("bp release rsp0_data", 32'(ch0.rsp_data), 32'h0022);
      ch0.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp drained rsp0_valid", 32'(ch0.rsp_valid), 32'd0);

      // Reset landing on the capture edge of a requester-1 grant; pointer was 1
      drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 3'd0, 16'h0100, 16'h0001);
      #1;
      chk("midrst ready1", 32'(ch1.req_ready), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst rsp1_valid", 32'(ch1.rsp_valid), 32'd0);
      chk("midrst rsp1_data", 32'(ch1.rsp_data), 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 3'd0, 16'h0001, 16'h0001, 1'b1, 3'd0, 16'h0002, 16'h0002);
      #1;
      chk("midrst rr ready0", 32'(ch0.req_ready), 32'd1);
      chk("midrst rr ready1", 32'(ch1.req_ready), 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
